// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITERS = 32;
    localparam int unsigned CNT_W = 5;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Two's-complement negate when n is set.
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + XLEN'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring divider over magnitudes, one quotient bit per step.
// Only instantiated when MULDIV_DIV_EN is defined.
module muldiv_divider
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quo_c,
    output logic [XLEN-1:0] rem_c
);

    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // quo shifts dividend bits out of the top while quotient bits enter the bottom.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[XLEN]) begin
            rem_c = diff[XLEN-1:0];
            quo_c = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_c = shifted[XLEN-1:0];
            quo_c = {quo[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (step) begin
            quo <= quo_c;
            rem <= rem_c;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with fixed 32-step latency.
// Divider is present only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [4:0]       rd_addr_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_addr_out
);

    state_t            state;
    state_t            state_n;
    logic              busy_n;
    logic              done_n;
    logic              accept;
    logic              last;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic [4:0]        tag;
    logic              neg_q;

    logic              sign_a;
    logic              sign_b;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   fast_result;

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_n;
    logic [2*XLEN-1:0] mul_fix;
    logic [XLEN-1:0]   mcand;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   final_result;

`ifdef MULDIV_DIV_EN
    logic              neg_r;
    logic              div_zero;
    logic              div_ovf;
    logic              div_fast;
    logic [XLEN-1:0]   quo_c;
    logic [XLEN-1:0]   rem_c;
    logic [XLEN-1:0]   div_res;
`endif

    assign last = (cnt == CNT_W'(ITERS - 1));

    // Operand signedness and magnitudes for the requested op.
    always_comb begin
        sign_a = funct3[2] ? ~funct3[0] : ((funct3 == F3_MULH) || (funct3 == F3_MULHSU));
        sign_b = funct3[2] ? ~funct3[0] : (funct3 == F3_MULH);
        neg_a  = sign_a & rs1_data[XLEN-1];
        neg_b  = sign_b & rs2_data[XLEN-1];
        mag_a  = neg_if(rs1_data, neg_a);
        mag_b  = neg_if(rs2_data, neg_b);
    end

`ifdef MULDIV_DIV_EN
    // Divide-by-zero and signed overflow finish without iterating.
    always_comb begin
        div_zero = (rs2_data == '0);
        div_ovf  = ~funct3[0] && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
        div_fast = div_zero | div_ovf;
        if (div_zero)
            fast_result = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
        else
            fast_result = funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
`else
    assign fast_result = '0;
`endif

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept = 1'b1;
                    if (!funct3[2]) begin
                        state_n = ST_MUL;
                    end else begin
`ifdef MULDIV_DIV_EN
                        state_n = div_fast ? ST_DONE : ST_DIV;
`else
                        state_n = ST_DONE;
`endif
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (last) state_n = ST_DONE;
            end
`ifdef MULDIV_DIV_EN
            ST_DIV: begin
                if (last) state_n = ST_DONE;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
        busy_n = (state_n == ST_MUL) || (state_n == ST_DIV);
        done_n = (state_n == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Shift-add step: conditionally add multiplicand to the high half, shift right.
    always_comb begin
        mul_sum = {1'b0, prod[2*XLEN-1:XLEN]} + ({1'b0, mcand} & {(XLEN+1){prod[0]}});
        prod_n  = {mul_sum, prod[XLEN-1:1]};
        mul_fix = neg_q ? (~prod_n + (2*XLEN)'(1)) : prod_n;
        mul_res = (op == F3_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    muldiv_divider u_divider (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && funct3[2] && !div_fast),
        .step     (state == ST_DIV),
        .dividend (mag_a),
        .divisor  (mag_b),
        .quo_c    (quo_c),
        .rem_c    (rem_c)
    );

    always_comb begin
        div_res      = op[1] ? neg_if(rem_c, neg_r) : neg_if(quo_c, neg_q);
        final_result = (state == ST_DIV) ? div_res : mul_res;
    end
`else
    assign final_result = mul_res;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            op          <= '0;
            tag         <= '0;
            neg_q       <= 1'b0;
            prod        <= '0;
            mcand       <= '0;
            result      <= '0;
            rd_addr_out <= '0;
`ifdef MULDIV_DIV_EN
            neg_r       <= 1'b0;
`endif
        end else if (accept) begin
            cnt   <= '0;
            op    <= funct3;
            tag   <= rd_addr_in;
            neg_q <= neg_a ^ neg_b;
            prod  <= {{XLEN{1'b0}}, mag_b};
            mcand <= mag_a;
`ifdef MULDIV_DIV_EN
            neg_r <= neg_a;
`endif
            if (state_n == ST_DONE) begin
                result      <= fast_result;
                rd_addr_out <= rd_addr_in;
            end
        end else if ((state == ST_MUL) || (state == ST_DIV)) begin
            cnt <= cnt + CNT_W'(1);
            if (state == ST_MUL) prod <= prod_n;
            if (last) begin
                result      <= final_result;
                rd_addr_out <= tag;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .funct3      (funct3),
        .rs1_data    (rs1),
        .rs2_data    (rs2),
        .rd_addr_in  (rd_in),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .rd_addr_out (rd_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            default: begin
                if (!DIV_EN) return 32'h0;
                if (b == 32'h0) return f[1] ? a : 32'hFFFF_FFFF;
                if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return f[1] ? 32'h0 : 32'h8000_0000;
                case (f)
                    3'd4:    return $signed(a) / $signed(b);
                    3'd5:    return a / b;
                    3'd6:    return $signed(a) % $signed(b);
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 33;
        if (!DIV_EN) return 1;
        if (b == 32'h0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Present a request for one edge, then scramble the operand inputs.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t);
        start  = 1'b1;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        rd_in  = t;
        @(posedge clk);
        #1;
        start  = 1'b0;
        rs1    = $urandom;
        rs2    = $urandom;
        rd_in  = 5'($urandom);
        funct3 = 3'($urandom);
    endtask

    // Wait (bounded) for done; optionally poke start while busy at cycle 'inject'.
    task automatic wait_done(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] t, input int inject, input string tag);
        int  cyc;
        bit  seen;
        int  exp_l;
        cyc   = 0;
        seen  = 1'b0;
        exp_l = ref_lat(f, a, b);
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) check({tag, "_busy"}, 32'(busy), 32'(exp_l > 1));
            if (done) begin
                seen = 1'b1;
            end else if (cyc == inject) begin
                start  = 1'b1;
                funct3 = 3'b101;
                rs2    = 32'h0;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(cyc), 32'(exp_l));
        check({tag, "_res"}, result, ref_res(f, a, b));
        check({tag, "_rd"}, 32'(rd_out), 32'(t));
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input string tag);
        @(negedge clk);
        launch(f, a, b, t);
        wait_done(f, a, b, t, 0, tag);
    endtask

    initial begin
        logic [31:0] rb;
        bit          saw;
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'h0;
        rs1    = 32'h0;
        rs2    = 32'h0;
        rd_in  = 5'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_rd", 32'(rd_out), 32'h0);
        rst = 1'b0;

        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd17, "mul_7xm3");
        @(negedge clk);
        check("done_drop", 32'(done), 32'd0);
        check("hold_result", result, 32'hFFFF_FFEB);
        check("hold_rd", 32'(rd_out), 32'd17);

        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, "mulh_min");
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhu_max");
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhsu_m1");
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, "div_m7_2");
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5, "rem_m7_2");
        do_op(3'b101, 32'd5, 32'd0, 5'd6, "divu_zero");
        do_op(3'b111, 32'd5, 32'd0, 5'd7, "remu_zero");
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, "div_ovf");
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, "rem_ovf");

        @(negedge clk);
        launch(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10);
        wait_done(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10, 5, "busy_ignore");
        launch(3'b000, 32'hDEAD_BEEF, 32'h0000_0101, 5'd11);
        wait_done(3'b000, 32'hDEAD_BEEF, 32'h0000_0101, 5'd11, 0, "b2b_mul");
        launch(3'b111, 32'd77, 32'd0, 5'd12);
        wait_done(3'b111, 32'd77, 32'd0, 5'd12, 0, "b2b_remu0");
        launch(3'b001, 32'hFFFF_FFF0, 32'h0000_0003, 5'd13);
        wait_done(3'b001, 32'hFFFF_FFF0, 32'h0000_0003, 5'd13, 0, "b2b_mulh");

        // Reset in the middle of a multiply.
        @(negedge clk);
        launch(3'b000, 32'h0000_1234, 32'h0000_5678, 5'd14);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'h0);
        check("abort_rd", 32'(rd_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw = 1'b1;
        end
        check("abort_nodone", 32'(saw), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);
        check("abort_idle_result", result, 32'h0);
        do_op(3'b000, 32'd6, 32'd7, 5'd15, "after_rst");

        repeat (60) begin
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            do_op(3'($urandom), ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
                  rb, 5'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
